// File: rtl/vc_random_stream_gen.sv
// Bounded, seedable pseudo-random value stream on a val/rdy interface.
// Emits a counted burst of folded xorshift values, rejecting candidates outside the limit.
module vc_random_stream_gen #(
    parameter int unsigned p_out_nbits   = 8,
    parameter logic [31:0] p_seed        = 32'hdeadbeef,
    parameter int unsigned p_count_nbits = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     seed_val,
    output logic                     seed_rdy,
    input  logic [31:0]              seed_data,

    input  logic                     start_val,
    output logic                     start_rdy,
    input  logic [p_count_nbits-1:0] start_count,
    input  logic [p_out_nbits-1:0]   start_limit,

    input  logic                     abort,

    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [p_out_nbits-1:0]   out_msg,

    output logic                     busy,
    output logic                     done
);

    localparam int unsigned c_nslices  = (32 + p_out_nbits - 1) / p_out_nbits;
    localparam int unsigned c_pad_bits = c_nslices * p_out_nbits;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_GEN  = 1'b1;

    logic [0:0]               state_q;
    logic [31:0]              s_q;
    logic [p_count_nbits-1:0] remaining_q;
    logic [p_out_nbits-1:0]   limit_q;
    logic                     done_q;

    logic [31:0]              t;
    logic [31:0]              s_next;
    logic [c_pad_bits-1:0]    s_pad;
    logic [p_out_nbits-1:0]   raw;
    logic [p_out_nbits-1:0]   lim_m1;
    logic [p_out_nbits-1:0]   mask;
    logic [p_out_nbits-1:0]   cand;
    logic                     accept;

    always_comb begin
        t      = s_q ^ (s_q >> 17);
        s_next = t ^ (t << 15);
    end

    // Fold: XOR of N-bit slices, the top slice zero-extended via the padded copy.
    always_comb begin
        s_pad        = '0;
        s_pad[31:0]  = s_q;
        raw          = '0;
        for (int unsigned k = 0; k < c_nslices; k++) begin
            raw = raw ^ s_pad[k*p_out_nbits +: p_out_nbits];
        end
    end

    // Smearing limit-1 rightwards gives the smallest all-ones mask covering it.
    always_comb begin
        lim_m1 = limit_q - p_out_nbits'(1);
        mask   = '0;
        for (int unsigned i = 0; i < p_out_nbits; i++) begin
            mask = mask | (lim_m1 >> i);
        end
        cand   = (limit_q == '0) ? raw : (raw & mask);
        accept = (limit_q == '0) || (cand < limit_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= STATE_IDLE;
            s_q         <= p_seed;
            remaining_q <= '0;
            limit_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == STATE_IDLE) begin
                if (seed_val) begin
                    s_q <= (seed_data == '0) ? p_seed : seed_data;
                end
                if (start_val) begin
                    remaining_q <= start_count;
                    limit_q     <= start_limit;
                    if (start_count == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        state_q <= STATE_GEN;
                    end
                end
            end else begin
                if (abort) begin
                    state_q <= STATE_IDLE;
                    done_q  <= 1'b1;
                end else if (!accept) begin
                    s_q <= s_next;
                end else if (out_rdy) begin
                    s_q         <= s_next;
                    remaining_q <= remaining_q - p_count_nbits'(1);
                    if (remaining_q == p_count_nbits'(1)) begin
                        state_q <= STATE_IDLE;
                        done_q  <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        seed_rdy  = (state_q == STATE_IDLE);
        start_rdy = (state_q == STATE_IDLE);
        busy      = reset_n && (state_q == STATE_GEN);
        out_val   = reset_n && (state_q == STATE_GEN) && accept;
        out_msg   = cand;
        done      = reset_n && done_q;
    end

endmodule

// File: tb/tb_vc_random_stream_gen.sv
// Randomised bench for vc_random_stream_gen against an arithmetic reference model.
module tb_vc_random_stream_gen;

    localparam int unsigned N      = 8;
    localparam int unsigned CW     = 16;
    localparam logic [31:0] P_SEED = 32'hdeadbeef;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          seed_val;
    logic          seed_rdy;
    logic [31:0]   seed_data;
    logic          start_val;
    logic          start_rdy;
    logic [CW-1:0] start_count;
    logic [N-1:0]  start_limit;
    logic          abort;
    logic          out_val;
    logic          out_rdy;
    logic [N-1:0]  out_msg;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ms;
    longint      got_q[$];
    longint      first_q[$];
    longint      ref_q[$];

    vc_random_stream_gen #(
        .p_out_nbits  (N),
        .p_seed       (P_SEED),
        .p_count_nbits(CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .seed_val   (seed_val),
        .seed_rdy   (seed_rdy),
        .seed_data  (seed_data),
        .start_val  (start_val),
        .start_rdy  (start_rdy),
        .start_count(start_count),
        .start_limit(start_limit),
        .abort      (abort),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_msg    (out_msg),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s >> 17);
        return t ^ (t << 15);
    endfunction

    function automatic longint m_fold(input logic [31:0] s);
        longint v = s;
        longint r = 0;
        longint m = 64'd1 << N;
        while (v != 0) begin
            r = r ^ (v % m);
            v = v / m;
        end
        return r;
    endfunction

    function automatic longint m_mask(input longint lim);
        longint m = 0;
        while (m < lim - 1) m = 2 * m + 1;
        return m;
    endfunction

    // Drives one start transaction (optionally with a seed load) and follows the burst cycle by cycle.
    task automatic do_burst(input int cnt, input int lim, input int stall_pct,
                            input int stall_at, input int abort_hs,
                            input bit do_seed, input logic [31:0] sd);
        int     hs = 0;
        int     cyc = 0;
        int     stall_left;
        bit     aborted = 0;
        longint raw, cand;
        bit     acc;
        got_q.delete();
        stall_left = (stall_at >= 0) ? 5 : 0;
        check_eq("start_rdy_idle", start_rdy, 1);
        check_eq("seed_rdy_idle", seed_rdy, 1);
        start_val   = 1'b1;
        start_count = CW'(cnt);
        start_limit = N'(lim);
        seed_val    = do_seed;
        seed_data   = sd;
        if (do_seed) ms = (sd == 0) ? P_SEED : sd;
        @(posedge clk); #1;
        start_val = 1'b0;
        seed_val  = 1'b0;
        if (cnt == 0) begin
            check_eq("zero_out_val", out_val, 0);
            check_eq("zero_busy", busy, 0);
            check_eq("zero_done", done, 1);
            @(posedge clk); #1;
            check_eq("zero_done_once", done, 0);
            return;
        end
        while (hs < cnt && cyc < 4000) begin
            cyc++;
            if (hs == stall_at && stall_left > 0) begin
                out_rdy = 1'b0;
                stall_left--;
            end else begin
                out_rdy = ($urandom_range(99) >= stall_pct);
            end
            abort = (hs == abort_hs);
            @(negedge clk);
            raw  = m_fold(ms);
            cand = (lim == 0) ? raw : (raw & m_mask(lim));
            acc  = (lim == 0) || (cand < lim);
            check_eq("busy_gen", busy, 1);
            check_eq("out_val", out_val, acc);
            if (acc) begin
                check_eq("out_msg", out_msg, cand);
                if (lim != 0) check_eq("in_range", (out_msg < lim), 1);
            end
            if (abort) aborted = 1;
            else if (!acc) ms = m_step(ms);
            else if (out_rdy) begin
                got_q.push_back(cand);
                hs++;
                ms = m_step(ms);
            end
            @(posedge clk); #1;
            if (aborted) break;
        end
        abort   = 1'b0;
        out_rdy = 1'b0;
        if (!aborted) check_eq("burst_timeout", hs, cnt);
        check_eq("end_busy", busy, 0);
        check_eq("end_done", done, 1);
        check_eq("end_out_val", out_val, 0);
        check_eq("end_start_rdy", start_rdy, 1);
        @(posedge clk); #1;
        check_eq("done_once", done, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        seed_val    = 1'b0;
        seed_data   = '0;
        start_val   = 1'b0;
        start_count = '0;
        start_limit = '0;
        abort       = 1'b0;
        out_rdy     = 1'b0;
        ms          = P_SEED;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_val", out_val, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_start_rdy", start_rdy, 1);

        do_burst(4, 0, 0, -1, -1, 1'b0, 32'h0);
        first_q = got_q;
        check_eq("first_len", first_q.size(), 4);

        do_burst(2, 0, 0, -1, -1, 1'b1, 32'h0);
        for (int i = 0; i < 2; i++) check_eq("zero_seed_repeat", got_q[i], first_q[i]);

        do_burst(10, 1, 20, -1, -1, 1'b0, 32'h0);
        foreach (got_q[i]) check_eq("limit1_zero", got_q[i], 0);
        do_burst(200, 5, 30, -1, -1, 1'b0, 32'h0);

        do_burst(3, 0, 0, -1, -1, 1'b1, 32'h1234_5678);
        ref_q = got_q;
        do_burst(3, 0, 0, 1, -1, 1'b1, 32'h1234_5678);
        check_eq("stall_len", got_q.size(), 3);
        for (int i = 0; i < 3; i++) check_eq("stall_seq", got_q[i], ref_q[i]);

        do_burst(5, 0, 0, -1, 1, 1'b0, 32'h0);
        check_eq("abort_count", got_q.size(), 1);
        do_burst(3, 0, 0, -1, -1, 1'b0, 32'h0);

        do_burst(0, 0, 0, -1, -1, 1'b0, 32'h0);

        for (int r = 0; r < 6; r++) begin
            do_burst(int'($urandom_range(20, 1)), int'($urandom_range(255)), 25, -1, -1,
                     ($urandom_range(1) == 1), $urandom);
        end

        start_val   = 1'b1;
        start_count = CW'(10);
        start_limit = '0;
        out_rdy     = 1'b1;
        @(posedge clk); #1;
        start_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_out_val", out_val, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        reset_n = 1'b1;
        out_rdy = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_no_done", done, 0);
        ms = P_SEED;
        do_burst(4, 0, 0, -1, -1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) check_eq("midrst_repeat", got_q[i], first_q[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
